ctrl_sequencer: RTL and testbench

- Parametrised hardwired control unit that steps the datapath through fetch and execute, replacing per-instruction hand-sequenced control stimulus.
- Drives the datapath's select/enable strobes one control step per Clock.
- Supports variable-length execute sequences per instruction class, a memory-ready handshake with timeout, and a halt state.

---
 rtl/ctrl_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute control sequencer: one control step per Clock, Moore-decoded strobes.
// Optional retired-instruction counter enabled by defining CTRL_SEQ_INSTR_COUNT_EN.
module ctrl_sequencer #(
    parameter int OPCODE_W    = 5,
    parameter int STEP_W      = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] IR_opcode,
    input  logic                Mem_ready,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                Yin,
    output logic                Zin,
    output logic                Cout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic                HIout,
    output logic                LOout,
    output logic [OPCODE_W-1:0] ALU_op,
    output logic                Run,
    output logic                Bus_error,
    output logic                Illegal_op,
    output logic [CNT_W-1:0]    Instr_count
);

    localparam logic [STEP_W-1:0] ST_RST  = STEP_W'(0);
    localparam logic [STEP_W-1:0] ST_T0   = STEP_W'(1);
    localparam logic [STEP_W-1:0] ST_T1   = STEP_W'(2);
    localparam logic [STEP_W-1:0] ST_T2   = STEP_W'(3);
    localparam logic [STEP_W-1:0] ST_T3   = STEP_W'(4);
    localparam logic [STEP_W-1:0] ST_T4   = STEP_W'(5);
    localparam logic [STEP_W-1:0] ST_T5   = STEP_W'(6);
    localparam logic [STEP_W-1:0] ST_T6   = STEP_W'(7);
    localparam logic [STEP_W-1:0] ST_T7   = STEP_W'(8);
    localparam logic [STEP_W-1:0] ST_HALT = STEP_W'(9);

    localparam logic [3:0] CL_RR   = 4'd0;
    localparam logic [3:0] CL_IMM  = 4'd1;
    localparam logic [3:0] CL_MD   = 4'd2;
    localparam logic [3:0] CL_NEG  = 4'd3;
    localparam logic [3:0] CL_MFHI = 4'd4;
    localparam logic [3:0] CL_MFLO = 4'd5;
    localparam logic [3:0] CL_NOP  = 4'd6;
    localparam logic [3:0] CL_HALT = 4'd7;
    localparam logic [3:0] CL_ILL  = 4'd8;

    function automatic logic [3:0] classify(input logic [OPCODE_W-1:0] op);
        int unsigned v;
        v = int'(op);
        if (v >= 3 && v <= 11)       return CL_RR;
        else if (v >= 12 && v <= 14) return CL_IMM;
        else if (v == 15 || v == 16) return CL_MD;
        else if (v == 17 || v == 18) return CL_NEG;
        else if (v == 24)            return CL_MFHI;
        else if (v == 25)            return CL_MFLO;
        else if (v == 26)            return CL_NOP;
        else if (v == 27)            return CL_HALT;
        else                         return CL_ILL;
    endfunction

    logic [STEP_W-1:0]   state_reg, state_next;
    logic [OPCODE_W-1:0] op_reg;
    logic [3:0]          class_reg;
    logic [3:0]          in_class;
    logic                last_step;
    logic                timeout_hit;
    logic                bus_error_reg;
    logic                illegal_reg;
    logic [OPCODE_W-1:0] imm_alu;

    assign in_class = classify(IR_opcode);

    // Final execute step per class; the edge leaving it retires the instruction.
    assign last_step = ((state_reg == ST_T6) && (class_reg == CL_RR || class_reg == CL_IMM)) ||
                       ((state_reg == ST_T7) && (class_reg == CL_MD)) ||
                       ((state_reg == ST_T5) && (class_reg == CL_NEG)) ||
                       ((state_reg == ST_T4) && (class_reg == CL_MFHI || class_reg == CL_MFLO));

    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout
            localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
            logic [TO_W-1:0] to_cnt_reg;

            // Counter starts at zero on entry to T2 because it is cleared while in T1.
            always_ff @(posedge Clock) begin
                if (Reset || state_reg == ST_T1) begin
                    to_cnt_reg <= '0;
                end else if (state_reg == ST_T2 && !Mem_ready) begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end

            assign timeout_hit = (state_reg == ST_T2) && !Mem_ready &&
                                 (({1'b0, to_cnt_reg} + 1'b1) == (TO_W + 1)'(MEM_TIMEOUT));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST: state_next = ST_T0;
            ST_T0:  state_next = ST_T1;
            ST_T1:  state_next = ST_T2;
            ST_T2: begin
                if (Mem_ready)        state_next = ST_T3;
                else if (timeout_hit) state_next = ST_HALT;
                else                  state_next = ST_T2;
            end
            ST_T3: begin
                case (in_class)
                    CL_NOP, CL_ILL: state_next = ST_T0;
                    CL_HALT:        state_next = ST_HALT;
                    default:        state_next = ST_T4;
                endcase
            end
            ST_T4:   state_next = last_step ? ST_T0 : ST_T5;
            ST_T5:   state_next = last_step ? ST_T0 : ST_T6;
            ST_T6:   state_next = last_step ? ST_T0 : ST_T7;
            ST_T7:   state_next = ST_T0;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_RST;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= ST_RST;
            op_reg        <= '0;
            class_reg     <= CL_NOP;
            bus_error_reg <= 1'b0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= (state_reg == ST_T3) && (in_class == CL_ILL);
            if (timeout_hit) begin
                bus_error_reg <= 1'b1;
            end
            if (state_reg == ST_T3) begin
                op_reg    <= IR_opcode;
                class_reg <= in_class;
            end
        end
    end

    always_comb begin
        case (int'(op_reg))
            12:      imm_alu = OPCODE_W'(3);
            13:      imm_alu = OPCODE_W'(10);
            default: imm_alu = OPCODE_W'(11);
        endcase
    end

    always_comb begin
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0;
        Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Cout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        ALU_op = '0;
        case (state_reg)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; end
            ST_T2: begin Read = 1'b1; MDRin = 1'b1; end
            ST_T3: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T4: begin
                case (class_reg)
                    CL_RR, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_MD:         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_NEG:        begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op_reg; end
                    CL_MFHI:       begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MFLO:       begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (class_reg)
                    CL_RR:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op_reg; end
                    CL_IMM: begin Cout = 1'b1; Zin = 1'b1; ALU_op = imm_alu; end
                    CL_MD:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op_reg; end
                    CL_NEG: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (class_reg)
                    CL_RR, CL_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MD:         begin Zlowout = 1'b1; LOin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T7: begin
                if (class_reg == CL_MD) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Run        = (state_reg != ST_HALT);
    assign Bus_error  = bus_error_reg;
    assign Illegal_op = illegal_reg;

`ifdef CTRL_SEQ_INSTR_COUNT_EN
    logic             retire;
    logic [CNT_W-1:0] instr_count_reg;

    assign retire = last_step || ((state_reg == ST_T3) && (in_class == CL_NOP));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_count_reg <= '0;
        end else if (retire) begin
            instr_count_reg <= instr_count_reg + 1'b1;
        end
    end

    assign Instr_count = instr_count_reg;
`else
    assign Instr_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomised bench for ctrl_sequencer against a per-instruction-class step-table model.
module tb_ctrl_sequencer;

    localparam int OW = 5;
    localparam int TO = 4;
    localparam int CW = 4;

    logic          Clock, Reset, Mem_ready;
    logic [OW-1:0] IR_opcode;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, Yin, Zin, Cout, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic [OW-1:0] ALU_op;
    logic          Run, Bus_error, Illegal_op;
    logic [CW-1:0] Instr_count;

    ctrl_sequencer #(.OPCODE_W(OW), .STEP_W(4), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset), .IR_opcode(IR_opcode), .Mem_ready(Mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .Yin(Yin), .Zin(Zin), .Cout(Cout), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .ALU_op(ALU_op), .Run(Run), .Bus_error(Bus_error), .Illegal_op(Illegal_op),
        .Instr_count(Instr_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [21:0] M_PCOUT = 22'd1 << 21, M_MARIN = 22'd1 << 20, M_INCPC = 22'd1 << 19;
    localparam logic [21:0] M_PCIN = 22'd1 << 18, M_READ = 22'd1 << 17, M_MDRIN = 22'd1 << 16;
    localparam logic [21:0] M_MDROUT = 22'd1 << 15, M_IRIN = 22'd1 << 14, M_GRA = 22'd1 << 13;
    localparam logic [21:0] M_GRB = 22'd1 << 12, M_GRC = 22'd1 << 11, M_RIN = 22'd1 << 10;
    localparam logic [21:0] M_ROUT = 22'd1 << 9, M_YIN = 22'd1 << 8, M_ZIN = 22'd1 << 7;
    localparam logic [21:0] M_COUT = 22'd1 << 6, M_ZLOW = 22'd1 << 5, M_ZHIGH = 22'd1 << 4;
    localparam logic [21:0] M_HIIN = 22'd1 << 3, M_LOIN = 22'd1 << 2, M_HIOUT = 22'd1 << 1;
    localparam logic [21:0] M_LOOUT = 22'd1 << 0;

    wire [21:0] obs = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Gra, Grb, Grc,
                       Rin, Rout, Yin, Zin, Cout, Zlowout, Zhighout, HIin, LOin, HIout, LOout};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model state
    int exp_count = 0;
    bit exp_be    = 1'b0;
    bit pend_ill  = 1'b0;
    bit bus_chk   = 1'b0;

    logic [21:0] ex_m[4];
    int          ex_a[4];
    int          ex_n;

    function automatic logic [31:0] count_exp();
`ifdef CTRL_SEQ_INSTR_COUNT_EN
        return 32'(exp_count % (1 << CW));
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge Clock) begin
        if (bus_chk)
            check("single_bus", 32'($countones({PCout, Zlowout, Zhighout, MDRout, Rout, Cout, HIout, LOout}) <= 1), 32'd1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [21:0] strobes, input int alu, input bit run);
        check({tag, ".strobes"}, 32'(obs), 32'(strobes));
        if (alu >= 0) check({tag, ".alu_op"}, 32'(ALU_op), 32'(alu));
        check({tag, ".run"}, 32'(Run), 32'(run));
        check({tag, ".bus_error"}, 32'(Bus_error), 32'(exp_be));
        check({tag, ".illegal"}, 32'(Illegal_op), 32'(pend_ill));
        check({tag, ".count"}, 32'(Instr_count), count_exp());
        $display("cycle %s strobes=%06h alu=%0d run=%0b be=%0b ill=%0b cnt=%0d", tag, obs, ALU_op, Run, Bus_error, Illegal_op, Instr_count);
    endtask

    // Execute-step table per instruction class
    task automatic plan(input int op);
        for (int k = 0; k < 4; k++) begin ex_m[k] = '0; ex_a[k] = -1; end
        ex_n = 0;
        if (op >= 3 && op <= 11) begin
            ex_n = 3; ex_m[0] = M_GRB | M_ROUT | M_YIN;
            ex_m[1] = M_GRC | M_ROUT | M_ZIN; ex_a[1] = op;
            ex_m[2] = M_ZLOW | M_GRA | M_RIN;
        end else if (op >= 12 && op <= 14) begin
            ex_n = 3; ex_m[0] = M_GRB | M_ROUT | M_YIN;
            ex_m[1] = M_COUT | M_ZIN; ex_a[1] = (op == 12) ? 3 : (op == 13) ? 10 : 11;
            ex_m[2] = M_ZLOW | M_GRA | M_RIN;
        end else if (op == 15 || op == 16) begin
            ex_n = 4; ex_m[0] = M_GRA | M_ROUT | M_YIN;
            ex_m[1] = M_GRB | M_ROUT | M_ZIN; ex_a[1] = op;
            ex_m[2] = M_ZLOW | M_LOIN; ex_m[3] = M_ZHIGH | M_HIIN;
        end else if (op == 17 || op == 18) begin
            ex_n = 2; ex_m[0] = M_GRB | M_ROUT | M_ZIN; ex_a[0] = op;
            ex_m[1] = M_ZLOW | M_GRA | M_RIN;
        end else if (op == 24) begin
            ex_n = 1; ex_m[0] = M_HIOUT | M_GRA | M_RIN;
        end else if (op == 25) begin
            ex_n = 1; ex_m[0] = M_LOOUT | M_GRA | M_RIN;
        end
    endtask

    // Leaves the DUT sampled in T0 (Reset held for two edges).
    task automatic do_reset();
        Reset = 1'b1;
        tick();
        exp_count = 0; exp_be = 1'b0; pend_ill = 1'b0;
        expect_cycle("rst", '0, 0, 1'b1);
        tick();
        expect_cycle("rst", '0, 0, 1'b1);
        Reset = 1'b0;
        tick();
    endtask

    task automatic expect_halted();
        expect_cycle("halt", '0, -1, 1'b0);
        tick();
        expect_cycle("halt", '0, -1, 1'b0);
    endtask

    // Runs one instruction starting in T0; abort_idx>=0 asserts Reset during that execute step.
    task automatic do_instr(input int op, input int stalls, input int abort_idx, output bit halted);
        halted = 1'b0;
        IR_opcode = OW'(op);
        plan(op);
        $display("instr op=%0d stalls=%0d abort=%0d", op, stalls, abort_idx);
        expect_cycle("T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, -1, 1'b1);
        pend_ill = 1'b0;
        tick();
        expect_cycle("T1", M_ZLOW | M_PCIN, -1, 1'b1);
        tick();
        for (int i = 0; ; i++) begin
            expect_cycle("T2", M_READ | M_MDRIN, -1, 1'b1);
            if (i < stalls) begin
                Mem_ready = 1'b0;
                tick();
                if (TO != 0 && i + 1 == TO) begin
                    exp_be = 1'b1;
                    halted = 1'b1;
                    expect_halted();
                    return;
                end
            end else begin
                Mem_ready = 1'b1;
                tick();
                break;
            end
        end
        expect_cycle("T3", M_MDROUT | M_IRIN, -1, 1'b1);
        tick();
        if (op == 27) begin
            halted = 1'b1;
            expect_halted();
            return;
        end
        if (op == 26) begin
            exp_count++;
            return;
        end
        if (ex_n == 0) begin
            pend_ill = 1'b1;
            return;
        end
        for (int k = 0; k < ex_n; k++) begin
            expect_cycle($sformatf("T%0d", k + 4), ex_m[k], ex_a[k], 1'b1);
            if (k == abort_idx) begin
                Reset = 1'b1;
                tick();
                exp_count = 0; exp_be = 1'b0; pend_ill = 1'b0;
                expect_cycle("rst_mid", '0, 0, 1'b1);
                Reset = 1'b0;
                tick();
                return;
            end
            tick();
        end
        exp_count++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int op, st;
        Reset = 1'b1; Mem_ready = 1'b0; IR_opcode = '0;
        do_reset();
        bus_chk = 1'b1;

        do_instr(12, 0, -1, h);
        do_instr(3, 3, -1, h);
        do_instr(15, 1, -1, h);
        do_instr(31, 0, -1, h);
        do_instr(17, 0, -1, h);
        do_instr(24, 2, -1, h);
        do_instr(25, 0, -1, h);
        do_instr(3, 0, 1, h);
        do_instr(13, 0, -1, h);
        do_instr(3, 10, -1, h);
        do_reset();
        do_instr(14, 0, -1, h);
        do_instr(27, 0, -1, h);
        do_reset();
        for (int n = 0; n < 16; n++) do_instr(26, n % 3, -1, h);
        do_instr(16, 0, -1, h);

        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 31);
            st = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            do_instr(op, st, -1, h);
            if (h) do_reset();
        end
        do_instr(18, 0, -1, h);

        bus_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
